// File: rtl/pfl_seq_pkg.sv
// pfl_seq_pkg: state encodings and page clamp shared by the PFL boot sequencer.
package pfl_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_LATCH    = 4'd1,
        S_GAP      = 4'd2,
        S_GRANT    = 4'd3,
        S_RECFG    = 4'd4,
        S_WAIT_CFG = 4'd5,
        S_FAIL     = 4'd6,
        S_DONE     = 4'd7,
        S_HALT     = 4'd8
    } state_e;

    function automatic int unsigned clamp_page(input int unsigned page, input int unsigned num_pages);
        return (page < num_pages) ? page : 32'd0;
    endfunction

endpackage

// File: rtl/pfl_seq_cnt.sv
// pfl_seq_cnt: loadable saturating down-counter with zero flag.
module pfl_seq_cnt #(
    parameter int unsigned W = 24
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load_i ? val_i : (cnt_q != '0) ? cnt_q - W'(1) : cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pfl_boot_sequencer.sv
// pfl_boot_sequencer: flash bus arbitration and PFL reconfiguration sequencing with retry/timeout.
// Define PFL_SEQ_FALLBACK_EN to fall back to factory page 0 once retries on another page are exhausted.
module pfl_boot_sequencer
    import pfl_seq_pkg::*;
#(
    parameter int unsigned ADDR_W      = 25,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned PAGE_W      = 3,
    parameter int unsigned NUM_PAGES   = 3,
    parameter int unsigned RST_CYC     = 16,
    parameter int unsigned RECFG_CYC   = 64,
    parameter int unsigned CFG_TIMEOUT = 2**24-1,
    parameter int unsigned MAX_RETRY   = 2
) (
    input  logic              clkin_max_100_i,
    input  logic              sys_resetn_i,
    input  logic              fc_done_i,
    input  logic [PAGE_W-1:0] fc_page_i,
    output logic              fc_req_o,
    input  logic              load_n_i,
    output logic              pfl_grant_o,
    output logic              pfl_nreset_o,
    output logic              pfl_nreconfigure_o,
    output logic [PAGE_W-1:0] fpga_pgm_o,
    input  logic              fpga_conf_done_i,
    input  logic              fpga_statusn_i,
    input  logic              fl_cen_i,
    input  logic              fl_oen_i,
    input  logic              fl_wen_i,
    input  logic              fl_advn_i,
    input  logic [ADDR_W-1:0] fl_addr_i,
    input  logic              pfl_cen_i,
    input  logic              pfl_oen_i,
    input  logic              pfl_wen_i,
    input  logic              pfl_advn_i,
    input  logic [ADDR_W-1:0] pfl_addr_i,
    output logic              flash_cen_o,
    output logic              flash_oen_o,
    output logic              flash_wen_o,
    output logic              flash_advn_o,
    output logic [ADDR_W-1:0] fsm_a_o,
    output logic              cfg_ok_o,
    output logic              cfg_fail_o,
    output logic [3:0]        state_dbg_o
);

    localparam int unsigned CW = $clog2(CFG_TIMEOUT + 1);
    localparam int unsigned RW = $clog2(MAX_RETRY + 2);

    state_e            state_q;
    logic [RW-1:0]     retry_q;
    logic              load_n_q, fc_req_q, pfl_grant_q, pfl_nreset_q, pfl_nreconfigure_q, cfg_ok_q, cfg_fail_q;
    logic [PAGE_W-1:0] fpga_pgm_q, page_clamped;
    logic              load_fall, gap, cnt_load, cnt_zero, fail_retry, fail_fallback, unused_cfg;
    logic [CW-1:0]     cnt_val;

    assign unused_cfg   = DATA_W[0];
    assign load_fall    = load_n_q & ~load_n_i;
    assign page_clamped = PAGE_W'(clamp_page(32'(fc_page_i), NUM_PAGES));
    assign fail_retry   = retry_q < RW'(MAX_RETRY);
`ifdef PFL_SEQ_FALLBACK_EN
    assign fail_fallback = (fpga_pgm_q != '0);
`else
    assign fail_fallback = 1'b0;
`endif

    // One shared counter times reset, reconfigure pulse and conf_done timeout in turn.
    assign cnt_load = (state_q == S_GAP) || (state_q == S_FAIL) || (state_q == S_DONE && load_fall) ||
                      (cnt_zero && (state_q == S_GRANT || state_q == S_RECFG));
    assign cnt_val  = (state_q == S_GAP)   ? CW'(RST_CYC - 1) :
                      (state_q == S_RECFG) ? CW'(CFG_TIMEOUT - 1) : CW'(RECFG_CYC - 1);

    pfl_seq_cnt #(.W(CW)) u_cnt (
        .clk_i   (clkin_max_100_i),
        .rst_n_i (sys_resetn_i),
        .load_i  (cnt_load),
        .val_i   (cnt_val),
        .zero_o  (cnt_zero)
    );

    always_ff @(posedge clkin_max_100_i) begin
        if (!sys_resetn_i) begin
            state_q            <= S_IDLE;
            retry_q            <= '0;
            load_n_q           <= 1'b1;
            fc_req_q           <= 1'b0;
            pfl_grant_q        <= 1'b0;
            pfl_nreset_q       <= 1'b0;
            pfl_nreconfigure_q <= 1'b1;
            fpga_pgm_q         <= '0;
            cfg_ok_q           <= 1'b0;
            cfg_fail_q         <= 1'b0;
        end else begin
            load_n_q <= load_n_i;
            case (state_q)
                S_IDLE: if (fc_done_i) state_q <= S_LATCH;
                S_LATCH: begin
                    fc_req_q   <= 1'b1;
                    fpga_pgm_q <= page_clamped;
                    retry_q    <= '0;
                    state_q    <= S_GAP;
                end
                S_GAP: begin
                    pfl_grant_q  <= 1'b1;
                    pfl_nreset_q <= 1'b0;
                    state_q      <= S_GRANT;
                end
                S_GRANT: if (cnt_zero) begin
                    pfl_nreset_q       <= 1'b1;
                    pfl_nreconfigure_q <= 1'b0;
                    state_q            <= S_RECFG;
                end
                S_RECFG: if (cnt_zero) begin
                    pfl_nreconfigure_q <= 1'b1;
                    state_q            <= S_WAIT_CFG;
                end
                S_WAIT_CFG: begin
                    if (fpga_conf_done_i) begin
                        cfg_ok_q <= 1'b1;
                        state_q  <= S_DONE;
                    end else if (!fpga_statusn_i || cnt_zero) begin
                        state_q <= S_FAIL;
                    end
                end
                S_FAIL: begin
                    if (fail_retry || fail_fallback) begin
                        retry_q            <= fail_retry ? retry_q + RW'(1) : '0;
                        fpga_pgm_q         <= fail_retry ? fpga_pgm_q : '0;
                        pfl_nreconfigure_q <= 1'b0;
                        state_q            <= S_RECFG;
                    end else begin
                        cfg_fail_q  <= 1'b1;
                        pfl_grant_q <= 1'b1;
                        state_q     <= S_HALT;
                    end
                end
                S_DONE: if (load_fall) begin
                    fpga_pgm_q         <= page_clamped;
                    cfg_ok_q           <= 1'b0;
                    retry_q            <= '0;
                    pfl_nreconfigure_q <= 1'b0;
                    state_q            <= S_RECFG;
                end
                S_HALT: begin
                    cfg_fail_q  <= 1'b1;
                    pfl_grant_q <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Bus handover: strobes parked inactive for the GAP cycle so neither master overlaps.
    assign gap          = (state_q == S_GAP);
    assign flash_cen_o  = gap | (pfl_grant_q ? pfl_cen_i : fl_cen_i);
    assign flash_oen_o  = gap | (pfl_grant_q ? pfl_oen_i : fl_oen_i);
    assign flash_wen_o  = gap | (pfl_grant_q ? pfl_wen_i : fl_wen_i);
    assign flash_advn_o = pfl_grant_q ? pfl_advn_i : fl_advn_i;
    assign fsm_a_o      = pfl_grant_q ? pfl_addr_i : fl_addr_i;

    assign fc_req_o           = fc_req_q;
    assign pfl_grant_o        = pfl_grant_q;
    assign pfl_nreset_o       = pfl_nreset_q;
    assign pfl_nreconfigure_o = pfl_nreconfigure_q;
    assign fpga_pgm_o         = fpga_pgm_q;
    assign cfg_ok_o           = cfg_ok_q;
    assign cfg_fail_o         = cfg_fail_q;
    assign state_dbg_o        = state_q;

endmodule

// File: tb/tb_pfl_boot_sequencer.sv
// tb_pfl_boot_sequencer: directed self-checking bench for pfl_boot_sequencer (CFG_TIMEOUT overridden to 1000).
module tb_pfl_boot_sequencer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        fc_done = 1'b0, load_n = 1'b1, conf_done = 1'b0, statusn = 1'b1;
    logic [2:0]  fc_page = '0;
    logic        fl_cen = 1'b0, fl_oen = 1'b0, fl_wen = 1'b1, fl_advn = 1'b0;
    logic        pfl_cen = 1'b0, pfl_oen = 1'b1, pfl_wen = 1'b0, pfl_advn = 1'b1;
    logic [24:0] fl_addr = 25'h0AAAAAA, pfl_addr = 25'h1555555;
    logic        fc_req, grant, nreset, nreconf, fl_cen_o, fl_oen_o, fl_wen_o, fl_advn_o, cfg_ok, cfg_fail;
    logic [2:0]  pgm;
    logic [24:0] fsm_a;
    logic [3:0]  st;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    pfl_boot_sequencer #(.CFG_TIMEOUT(1000)) dut (
        .clkin_max_100_i(clk), .sys_resetn_i(rstn), .fc_done_i(fc_done), .fc_page_i(fc_page),
        .fc_req_o(fc_req), .load_n_i(load_n), .pfl_grant_o(grant), .pfl_nreset_o(nreset),
        .pfl_nreconfigure_o(nreconf), .fpga_pgm_o(pgm), .fpga_conf_done_i(conf_done),
        .fpga_statusn_i(statusn), .fl_cen_i(fl_cen), .fl_oen_i(fl_oen), .fl_wen_i(fl_wen),
        .fl_advn_i(fl_advn), .fl_addr_i(fl_addr), .pfl_cen_i(pfl_cen), .pfl_oen_i(pfl_oen),
        .pfl_wen_i(pfl_wen), .pfl_advn_i(pfl_advn), .pfl_addr_i(pfl_addr), .flash_cen_o(fl_cen_o),
        .flash_oen_o(fl_oen_o), .flash_wen_o(fl_wen_o), .flash_advn_o(fl_advn_o), .fsm_a_o(fsm_a),
        .cfg_ok_o(cfg_ok), .cfg_fail_o(cfg_fail), .state_dbg_o(st)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input string tag, input logic [3:0] s, input int budget);
        int n = 0;
        while (st != s && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(st), 32'(s));
    endtask

    // sel 0: nreset low, 1: nreconfigure low, 2: in WAIT_CFG
    task automatic count_while(input string tag, input int sel, input int exp, input int budget);
        int n = 0;
        while (n < budget && ((sel == 0 && !nreset) || (sel == 1 && !nreconf) || (sel == 2 && st == 4'd5))) begin
            tick();
            n++;
        end
        check(tag, 32'(n), 32'(exp));
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        int attempts;
        // reset state and pre-grant routing
        tick();
        tick();
        check("rst_state", 32'(st), 0);
        check("rst_fc_req", 32'(fc_req), 0);
        check("rst_grant", 32'(grant), 0);
        check("rst_nreset", 32'(nreset), 0);
        check("rst_nreconf", 32'(nreconf), 1);
        check("rst_pgm", 32'(pgm), 0);
        check("rst_ok", 32'(cfg_ok), 0);
        check("rst_fail", 32'(cfg_fail), 0);
        check("rst_addr_fl", 32'(fsm_a), 32'(fl_addr));
        check("rst_oen_fl", 32'(fl_oen_o), 0);
        // nominal boot of page 1
        rstn = 1'b1;
        fc_done = 1'b1;
        fc_page = 3'd1;
        tick();
        check("latch_state", 32'(st), 1);
        check("latch_cen", 32'(fl_cen_o), 0);
        tick();
        check("gap_state", 32'(st), 2);
        check("gap_cen", 32'(fl_cen_o), 1);
        check("gap_oen", 32'(fl_oen_o), 1);
        check("gap_pgm", 32'(pgm), 1);
        check("gap_fc_req", 32'(fc_req), 1);
        tick();
        fc_done = 1'b0;
        check("grant_state", 32'(st), 3);
        check("grant_grant", 32'(grant), 1);
        check("grant_cen_pfl", 32'(fl_cen_o), 0);
        check("grant_wen_pfl", 32'(fl_wen_o), 0);
        check("grant_addr_pfl", 32'(fsm_a), 32'(pfl_addr));
        count_while("nreset_low_cyc", 0, 16, 100);
        check("recfg_state", 32'(st), 4);
        count_while("nreconf_low_cyc", 1, 64, 200);
        check("wait_state", 32'(st), 5);
        repeat (99) tick();
        check("still_waiting", 32'(st), 5);
        conf_done = 1'b1;
        statusn = 1'b0;
        tick();
        statusn = 1'b1;
        check("conf_wins_state", 32'(st), 7);
        check("done_ok", 32'(cfg_ok), 1);
        check("done_pgm", 32'(pgm), 1);
        // user reload to page 2 while DONE
        fc_page = 3'd2;
        load_n = 1'b0;
        tick();
        load_n = 1'b1;
        check("reload_state", 32'(st), 4);
        check("reload_ok", 32'(cfg_ok), 0);
        check("reload_pgm", 32'(pgm), 2);
        check("reload_grant", 32'(grant), 1);
        count_while("reload_nreconf_cyc", 1, 64, 200);
        wait_state("reload_done", 4'd7, 5);
        // out-of-range page clamps to 0, then timeout
        conf_done = 1'b0;
        do_reset();
        fc_page = 3'd5;
        fc_done = 1'b1;
        wait_state("to_wait", 4'd5, 200);
        fc_done = 1'b0;
        check("clamp_pgm", 32'(pgm), 0);
        count_while("timeout_cyc", 2, 1000, 1100);
        check("timeout_fail", 32'(st), 6);
        tick();
        check("retry_recfg", 32'(st), 4);
        rstn = 1'b0;
        tick();
        check("midrst_state", 32'(st), 0);
        check("midrst_grant", 32'(grant), 0);
        check("midrst_nreconf", 32'(nreconf), 1);
        // statusn error on every attempt of page 2
        do_reset();
        fc_page = 3'd2;
        fc_done = 1'b1;
        statusn = 1'b0;
        wait_state("err_recfg", 4'd4, 100);
        fc_done = 1'b0;
        attempts = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (st == 4'd6) attempts++;
            if (st == 4'd8 || pgm == 3'd0) break;
        end
        check("err_attempts", 32'(attempts), 3);
`ifdef PFL_SEQ_FALLBACK_EN
        check("fb_state", 32'(st), 4);
        check("fb_pgm", 32'(pgm), 0);
        statusn = 1'b1;
        conf_done = 1'b1;
        wait_state("fb_done", 4'd7, 200);
        check("fb_ok", 32'(cfg_ok), 1);
        check("fb_pgm_done", 32'(pgm), 0);
`else
        check("halt_state", 32'(st), 8);
        check("halt_fail", 32'(cfg_fail), 1);
        check("halt_grant", 32'(grant), 1);
        statusn = 1'b1;
        conf_done = 1'b1;
        repeat (5) tick();
        check("halt_sticky", 32'(st), 8);
        check("halt_ok", 32'(cfg_ok), 0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
